// File: rtl/bus_write_ctrl_pkg.sv
// Shared definitions for bus_write_ctrl: FIFO entry layout {clr, addr, data}
// and the issue FSM encoding.
package bus_write_ctrl_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   localparam int DATA_LSB = 0;

   function automatic int addr_lsb(input int width);
      return width;
   endfunction

   function automatic int clr_bit(input int width, input int addr_w);
      return width + addr_w;
   endfunction

   function automatic int entry_w(input int width, input int addr_w);
      return width + addr_w + 1;
   endfunction

endpackage

// File: rtl/bus_write_ctrl_sync_fifo.sv
// Request FIFO: output is combinational from the head, one cycle from push to visible.
// No pass-through when full; flush clears first, then a same-edge push lands in slot 0.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     RST,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rptr;
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    waddr;

   assign dout  = mem[rptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign waddr = flush ? '0 : wptr;

   always_ff @(posedge Clk) begin
      if (push)
         mem[waddr] <= din;
   end

   always_ff @(posedge Clk) begin
      if (!RST) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (flush) begin
         rptr  <= '0;
         wptr  <= push ? PW'(1) : '0;
         count <= push ? CW'(1) : '0;
      end else begin
         if (push)
            wptr <= wptr + PW'(1);
         if (pop)
            rptr <= rptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/bus_write_ctrl.sv
// Buffers write/clear requests and issues one per cycle as one-hot WEN / reg_clr strobes.
// Strobe follows acceptance by one edge; req_ready drops only when the FIFO is full.
module bus_write_ctrl
   import bus_write_ctrl_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2,
   parameter int DEPTH    = 4
) (
   input  logic                Clk,
   input  logic                RST,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                req_clr,
   input  logic [WIDTH-1:0]    req_data,
   input  logic                stall,
   input  logic                flush,
   output logic [WIDTH-1:0]    BusOut,
   output logic [NUM_REGS-1:0] WEN,
   output logic [NUM_REGS-1:0] reg_clr,
   output logic                busy,
   output logic                err
);

   localparam int EW  = entry_w(WIDTH, ADDR_W);
   localparam int AL  = addr_lsb(WIDTH);
   localparam int CB  = clr_bit(WIDTH, ADDR_W);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int AW1 = ADDR_W + 1;
   localparam logic [AW1-1:0] NREGS = AW1'(NUM_REGS);

   logic [EW-1:0]       din;
   logic [EW-1:0]       dout;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic [CW-1:0]       count;
   logic [0:0]          state;
   logic [ADDR_W-1:0]   head_addr;
   logic                head_clr;
   logic [WIDTH-1:0]    head_data;
   logic                head_ok;
   logic [NUM_REGS-1:0] head_onehot;

   assign req_ready = !full;
   assign push      = req_valid && req_ready;
   assign din       = {req_clr, req_addr, req_data};

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .Clk   (Clk),
      .RST   (RST),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign head_data = dout[DATA_LSB +: WIDTH];
   assign head_addr = dout[AL +: ADDR_W];
   assign head_clr  = dout[CB];
   assign head_ok   = ({1'b0, head_addr} < NREGS);

   always_comb begin
      state = ST_IDLE;
      if (!empty && !stall)
         state = ST_ISSUE;
   end

   // Flush wins over issue: the head being discarded must not reach the bus.
   assign pop = (state == ST_ISSUE) && !flush;

   always_comb begin
      head_onehot = '0;
      for (int i = 0; i < NUM_REGS; i++)
         head_onehot[i] = ({1'b0, head_addr} == AW1'(i));
   end

   always_ff @(posedge Clk) begin
      if (!RST) begin
         BusOut  <= '0;
         WEN     <= '0;
         reg_clr <= '0;
         err     <= 1'b0;
      end else begin
         WEN     <= '0;
         reg_clr <= '0;
         if (pop) begin
            if (!head_ok) begin
               err <= 1'b1;
            end else if (head_clr) begin
               BusOut  <= '0;
               reg_clr <= head_onehot;
            end else begin
               BusOut <= head_data;
               WEN    <= head_onehot;
            end
         end
      end
   end

   assign busy = (count != '0) || (|WEN) || (|reg_clr);

endmodule
